// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: synchronizes the raw PS/2 lines, receives 11-bit frames,
// parses make/break sequences and tracks the held key plus a two-digit BCD press count.
// Optional feature: define PS2_PARITY_CHECK_EN to drop frames with bad odd parity.
module ps2_key_tracker #(
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] code_hi,
  output logic [3:0] code_lo,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_ones,
  output logic       key_down,
  output logic       blank,
  output logic       byte_valid,
  output logic [7:0] byte_out,
  output logic       frame_err
);

  localparam int unsigned ToW = $clog2(TIMEOUT + 1);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT - 1);

`ifdef PS2_PARITY_CHECK_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  localparam logic [7:0] CodeExt   = 8'hE0;
  localparam logic [7:0] CodeBreak = 8'hF0;

  typedef enum logic [0:0] {StIdle, StBreak} state_e;

  // ---------------------------------------------------------------------------
  // Synchronizers; index 0 is the newest stage. Reset to all-1s = bus idle.
  // ---------------------------------------------------------------------------
  logic [2:0] clk_sync_q;
  logic [2:0] data_sync_q;
  logic       fall;
  logic       sdata;

  // Three-stage synchronizers for both PS/2 lines
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q  <= 3'b111;
      data_sync_q <= 3'b111;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
      data_sync_q <= {data_sync_q[1:0], ps2_data};
    end
  end

  // Older stage high, newer stage low; data taken from the oldest stage, which the
  // device held stable throughout the preceding clock-high phase.
  assign fall  = clk_sync_q[2] & ~clk_sync_q[1];
  assign sdata = data_sync_q[2];

  // ---------------------------------------------------------------------------
  // Frame receiver with idle timeout
  // ---------------------------------------------------------------------------
  logic [3:0]     bitcnt_q, bitcnt_d;
  logic [9:0]     sr_q, sr_d;          // start, data[7:0], parity after ten shifts
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]     byte_q, byte_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;
  logic           parity_ok;
  logic           frame_ok;

  // Data+parity must have an odd number of ones when the check is enabled
  assign parity_ok = ~ParityEn | (^sr_q[9:1]);
  assign frame_ok  = ~sr_q[0] & sdata & parity_ok;

  // Receiver next state: shift on each fall, judge the frame on the stop-bit fall
  always_comb begin
    bitcnt_d = bitcnt_q;
    sr_d     = sr_q;
    to_cnt_d = to_cnt_q;
    byte_d   = byte_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    if (fall) begin
      // A fall always wins over a simultaneous timeout terminal count
      to_cnt_d = '0;
      if (bitcnt_q == 4'd10) begin
        bitcnt_d = 4'd0;
        if (frame_ok) begin
          valid_d = 1'b1;
          byte_d  = sr_q[8:1];
        end else begin
          err_d = 1'b1;
        end
      end else begin
        sr_d     = {sdata, sr_q[9:1]};
        bitcnt_d = bitcnt_q + 4'd1;
      end
    end else if (bitcnt_q != 4'd0) begin
      if (to_cnt_q == ToLast) begin
        // Abandon the partial frame silently
        bitcnt_d = 4'd0;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  // Receiver state registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bitcnt_q <= 4'd0;
      sr_q     <= '0;
      to_cnt_q <= '0;
      byte_q   <= 8'h00;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      bitcnt_q <= bitcnt_d;
      sr_q     <= sr_d;
      to_cnt_q <= to_cnt_d;
      byte_q   <= byte_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Make/break parser and BCD press counter
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [7:0] code_q, code_d;
  logic       key_down_q, key_down_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;

  // Parser next state: acts only on accepted bytes
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    key_down_d = key_down_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    if (valid_q) begin
      unique case (state_q)
        StIdle: begin
          if (byte_q == CodeExt) begin
            state_d = StIdle;
          end else if (byte_q == CodeBreak) begin
            state_d = StBreak;
          end else if (!(key_down_q && (byte_q == code_q))) begin
            // New press; typematic repeats of the held key fall through untouched
            code_d     = byte_q;
            key_down_d = 1'b1;
            if (ones_q == 4'd9) begin
              ones_d = 4'd0;
              tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
            end else begin
              ones_d = ones_q + 4'd1;
            end
          end
        end
        StBreak: begin
          if (byte_q != CodeExt) begin
            if (byte_q == code_q) begin
              key_down_d = 1'b0;
            end
            state_d = StIdle;
          end
        end
      endcase
    end
  end

  // Parser state registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= StIdle;
      code_q     <= 8'h00;
      key_down_q <= 1'b0;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      key_down_q <= key_down_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
    end
  end

  assign code_hi    = code_q[7:4];
  assign code_lo    = code_q[3:0];
  assign cnt_tens   = tens_q;
  assign cnt_ones   = ones_q;
  assign key_down   = key_down_q;
  assign blank      = ~key_down_q;
  assign byte_valid = valid_q;
  assign byte_out   = byte_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: bit-banged PS/2 frames, a behavioural
// key/count model, and per-frame checks of pulses and parser outputs.
module tb_ps2_key_tracker;

  localparam int unsigned TbTimeout = 200;

`ifdef PS2_PARITY_CHECK_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] code_hi, code_lo, cnt_tens, cnt_ones;
  logic       key_down, blank, byte_valid, frame_err;
  logic [7:0] byte_out;

  ps2_key_tracker #(.TIMEOUT(TbTimeout)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .code_hi    (code_hi),
    .code_lo    (code_lo),
    .cnt_tens   (cnt_tens),
    .cnt_ones   (cnt_ones),
    .key_down   (key_down),
    .blank      (blank),
    .byte_valid (byte_valid),
    .byte_out   (byte_out),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_err   = 0;

  // Reference model state
  logic [7:0] m_code;
  logic       m_down;
  int         m_count;
  bit         m_break;
  logic [7:0] m_byte;

  // Pulse counters, sampled away from the active edge
  always @(negedge clk) begin
    if (clrn) begin
      if (byte_valid) n_valid++;
      if (frame_err) n_err++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_code = 8'h00; m_down = 1'b0; m_count = 0; m_break = 0; m_byte = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b);
    m_byte = b;
    if (m_break) begin
      if (b != 8'hE0) begin
        if (b == m_code) m_down = 1'b0;
        m_break = 0;
      end
    end else if (b == 8'hF0) begin
      m_break = 1;
    end else if (b != 8'hE0 && !(m_down && b == m_code)) begin
      m_code  = b;
      m_down  = 1'b1;
      m_count = (m_count + 1) % 100;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".code"}, {code_hi, code_lo}, m_code);
    check({tag, ".tens"}, cnt_tens, m_count / 10);
    check({tag, ".ones"}, cnt_ones, m_count % 10);
    check({tag, ".key_down"}, key_down, m_down);
    check({tag, ".blank"}, blank, !m_down);
    check({tag, ".byte_out"}, byte_out, m_byte);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_clks(4);
    ps2_clk = 1'b0;
    wait_clks(8);
    ps2_clk = 1'b1;
    wait_clks(4);
  endtask

  // Sends one frame and checks pulse counts plus the resulting parser state
  task automatic do_frame(input string tag, input logic [7:0] b, input bit bad_par,
                          input bit bad_start, input bit bad_stop);
    int  v0, e0;
    bit  acc;
    logic par;
    v0  = n_valid;
    e0  = n_err;
    par = (~^b) ^ bad_par;
    send_bit(bad_start);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(!bad_stop);
    ps2_data = 1'b1;
    wait_clks(4);
    acc = !bad_start && !bad_stop && !(ParityEn && bad_par);
    check({tag, ".valid_cnt"}, n_valid - v0, acc ? 1 : 0);
    check({tag, ".err_cnt"}, n_err - e0, acc ? 0 : 1);
    if (acc) model_byte(b);
    check_outputs(tag);
  endtask

  initial begin
    logic [7:0] prev;
    logic [7:0] k;
    logic [7:0] pool [5];
    pool[0] = 8'h1C; pool[1] = 8'h2B; pool[2] = 8'h45; pool[3] = 8'h1B; pool[4] = 8'h23;
    model_reset();
    wait_clks(3);
    check("reset.byte_valid", byte_valid, 1'b0);
    check("reset.frame_err", frame_err, 1'b0);
    check_outputs("reset");
    clrn = 1'b1;
    wait_clks(3);

    // Make, typematic repeats, release
    do_frame("make", 8'h1C, 0, 0, 0);
    for (int i = 0; i < 3; i++) do_frame("repeat", 8'h1C, 0, 0, 0);
    do_frame("brk_f0", 8'hF0, 0, 0, 0);
    do_frame("brk_key", 8'h1C, 0, 0, 0);

    // Parity error, then framing errors
    do_frame("parity", 8'h1C, 1, 0, 0);
    do_frame("bad_start", 8'h33, 0, 1, 0);
    do_frame("bad_stop", 8'h34, 0, 0, 1);

    // Partial frame abandoned by timeout
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    ps2_data = 1'b1;
    wait_clks(TbTimeout + 10);
    do_frame("timeout", 8'h2B, 0, 0, 0);

    // 100 make/break pairs of distinct keys: count passes 09->10 and 99->00
    prev = m_code;
    for (int i = 0; i < 100; i++) begin
      do begin
        k = 8'($urandom_range(1, 127));
      end while (k == prev);
      prev = k;
      do_frame("wrap_make", k, 0, 0, 0);
      do_frame("wrap_brk", 8'hF0, 0, 0, 0);
      do_frame("wrap_key", k, 0, 0, 0);
    end

    // Random byte stream with E0/F0 prefixes and occasional bad frames
    for (int i = 0; i < 40; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) k = 8'hE0;
      else if (r < 3) k = 8'hF0;
      else k = pool[$urandom_range(0, 4)];
      do_frame("rand", k, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 19) == 0));
    end

    // Reset mid-frame: asynchronous clear, then a clean frame
    do_frame("pre_rst", 8'h1C, 0, 0, 0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk);
    #2 clrn = 1'b0;
    #1;
    model_reset();
    check("rst_async.byte_valid", byte_valid, 1'b0);
    check("rst_async.frame_err", frame_err, 1'b0);
    check_outputs("rst_async");
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_clks(3);
    clrn = 1'b1;
    wait_clks(3);
    do_frame("post_rst", 8'h45, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard bound so the run cannot hang
  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
